// File: rtl/regfile_sb_if.sv
// ============================================================================
// regfile_sb_if : read/forward/write/scoreboard bundle for regfile_sb
// Revision: 1.0
// ============================================================================
`default_nettype none

interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = 2,
    parameter int CNTW = 16
);
    logic                wb_we_i;
    logic [AW-1:0]       wb_waddr_i;
    logic [XLEN-1:0]     wb_wdata_i;
    logic                wb_ld_i;
    logic                mem_we_i;
    logic                mem_ld_i;
    logic [AW-1:0]       mem_waddr_i;
    logic [XLEN-1:0]     mem_wdata_i;
    logic                ex_we_i;
    logic                ex_ld_i;
    logic [AW-1:0]       ex_waddr_i;
    logic [XLEN-1:0]     ex_alu_i;
    logic                ld_issue_i;
    logic [AW-1:0]       ld_issue_addr_i;
    logic [NRD-1:0]      re_i;
    logic [NRD*AW-1:0]   raddr_i;
    logic [NRD*XLEN-1:0] rdata_o;
    logic                stallreq_o;
    logic [NREG-1:0]     pending_o;
    logic [CNTW-1:0]     stall_cnt_o;

    modport slave (
        input  wb_we_i, wb_waddr_i, wb_wdata_i, wb_ld_i,
        input  mem_we_i, mem_ld_i, mem_waddr_i, mem_wdata_i,
        input  ex_we_i, ex_ld_i, ex_waddr_i, ex_alu_i,
        input  ld_issue_i, ld_issue_addr_i, re_i, raddr_i,
        output rdata_o, stallreq_o, pending_o, stall_cnt_o
    );

    modport master (
        output wb_we_i, wb_waddr_i, wb_wdata_i, wb_ld_i,
        output mem_we_i, mem_ld_i, mem_waddr_i, mem_wdata_i,
        output ex_we_i, ex_ld_i, ex_waddr_i, ex_alu_i,
        output ld_issue_i, ld_issue_addr_i, re_i, raddr_i,
        input  rdata_o, stallreq_o, pending_o, stall_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// regfile_sb : register file with EX/MEM/WB forwarding, pending-load
//              scoreboard, load-use stall detection and stall counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = 2,
    parameter int CNTW = 16
) (
    input  wire logic    clk,
    input  wire logic    rst,
    regfile_sb_if.slave  bus
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic [CNTW-1:0] stall_cnt_q;
    logic [CNTW-1:0] stall_cnt_d;
    logic [NRD-1:0]  w_port_stall;
    logic            w_stall;

    generate
        for (genvar k = 0; k < NRD; k++) begin : g_rd_port
            logic [AW-1:0]   w_addr;
            logic [XLEN-1:0] w_data;
            logic            w_stl;

            assign w_addr = bus.raddr_i[k*AW +: AW];

            always_comb begin
                w_data = '0;
                w_stl  = 1'b0;
                if (!bus.re_i[k] || (w_addr == '0)) begin
                    w_data = '0;
                end else if (bus.ex_we_i && (w_addr == bus.ex_waddr_i)) begin
                    if (bus.ex_ld_i) w_stl  = 1'b1;
                    else             w_data = bus.ex_alu_i;
                end else if (bus.mem_we_i && (w_addr == bus.mem_waddr_i)) begin
                    if (bus.mem_ld_i) w_stl  = 1'b1;
                    else              w_data = bus.mem_wdata_i;
                end else if (bus.wb_we_i && (w_addr == bus.wb_waddr_i)) begin
                    // a returning load is forwarded even though its pending bit is still set
                    w_data = bus.wb_wdata_i;
                end else if (pending_q[w_addr]) begin
                    w_stl  = 1'b1;
                end else begin
                    w_data = regs_q[w_addr];
                end
            end

            assign bus.rdata_o[k*XLEN +: XLEN] = rst ? '0 : w_data;
            assign w_port_stall[k]             = w_stl;
        end
    endgenerate

    assign w_stall         = !rst && (|w_port_stall);
    assign bus.stallreq_o  = w_stall;
    assign bus.pending_o   = pending_q;
    assign bus.stall_cnt_o = stall_cnt_q;

    // Clear first so that a same-cycle issue to the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (bus.wb_we_i && bus.wb_ld_i) begin
            pending_d[bus.wb_waddr_i] = 1'b0;
        end
        if (bus.ld_issue_i && (bus.ld_issue_addr_i != '0)) begin
            pending_d[bus.ld_issue_addr_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (w_stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
            if (bus.wb_we_i && (bus.wb_waddr_i != '0)) begin
                regs_q[bus.wb_waddr_i] <= bus.wb_wdata_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// tb_regfile_sb : directed + randomized bench for regfile_sb (CNTW=4 build)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;
    localparam int CNTW = 4;
    localparam int CMAX = 15;

    logic clk;
    logic rst;

    regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .CNTW(CNTW)) bus ();

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // reference state
    logic [XLEN-1:0] m_regs [NREG];
    bit   [NREG-1:0] m_pend;
    int              m_cnt;
    bit              m_rst;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        m_pend = '0;
        m_cnt  = 0;
    endtask

    function automatic void exp_port(input int k, output logic [XLEN-1:0] d, output bit s);
        logic [AW-1:0] a;
        a = bus.raddr_i[k*AW +: AW];
        d = '0;
        s = 1'b0;
        if (m_rst || !bus.re_i[k] || a == 0) begin
            d = '0;
        end else if (bus.ex_we_i && a == bus.ex_waddr_i) begin
            if (bus.ex_ld_i) s = 1'b1; else d = bus.ex_alu_i;
        end else if (bus.mem_we_i && a == bus.mem_waddr_i) begin
            if (bus.mem_ld_i) s = 1'b1; else d = bus.mem_wdata_i;
        end else if (bus.wb_we_i && a == bus.wb_waddr_i) begin
            d = bus.wb_wdata_i;
        end else if (m_pend[a]) begin
            s = 1'b1;
        end else begin
            d = m_regs[a];
        end
    endfunction

    function automatic bit exp_stall();
        logic [XLEN-1:0] d;
        bit s;
        bit any;
        any = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            exp_port(k, d, s);
            any |= s;
        end
        return any;
    endfunction

    task automatic check_all(input string tag);
        logic [XLEN-1:0] d;
        bit s;
        for (int k = 0; k < NRD; k++) begin
            exp_port(k, d, s);
            chk($sformatf("%s.rdata%0d", tag, k), 64'(bus.rdata_o[k*XLEN +: XLEN]), 64'(d));
        end
        chk({tag, ".stall"},   64'(bus.stallreq_o),  64'(exp_stall()));
        chk({tag, ".pending"}, 64'(bus.pending_o),   64'(m_pend));
        chk({tag, ".cnt"},     64'(bus.stall_cnt_o), 64'(m_cnt));
    endtask

    // Advance one clock and update the model from the inputs held across the edge.
    task automatic tick();
        bit [NREG-1:0]   np;
        int              nc;
        bit              wr;
        logic [AW-1:0]   wa;
        logic [XLEN-1:0] wd;
        np = m_pend;
        nc = m_cnt;
        wr = 1'b0;
        wa = bus.wb_waddr_i;
        wd = bus.wb_wdata_i;
        if (!m_rst) begin
            wr = bus.wb_we_i && (bus.wb_waddr_i != 0);
            if (bus.wb_we_i && bus.wb_ld_i) np[bus.wb_waddr_i] = 1'b0;
            if (bus.ld_issue_i && bus.ld_issue_addr_i != 0) np[bus.ld_issue_addr_i] = 1'b1;
            if (exp_stall() && m_cnt < CMAX) nc = m_cnt + 1;
        end
        @(posedge clk);
        m_pend = np;
        m_cnt  = nc;
        if (wr) m_regs[wa] = wd;
        #1;
    endtask

    task automatic idle();
        bus.wb_we_i = 0; bus.wb_waddr_i = 0; bus.wb_wdata_i = 0; bus.wb_ld_i = 0;
        bus.mem_we_i = 0; bus.mem_ld_i = 0; bus.mem_waddr_i = 0; bus.mem_wdata_i = 0;
        bus.ex_we_i = 0; bus.ex_ld_i = 0; bus.ex_waddr_i = 0; bus.ex_alu_i = 0;
        bus.ld_issue_i = 0; bus.ld_issue_addr_i = 0;
        bus.re_i = '0; bus.raddr_i = '0;
    endtask

    task automatic rd(input int k, input logic [AW-1:0] a);
        bus.re_i[k] = 1'b1;
        bus.raddr_i[k*AW +: AW] = a;
    endtask

    initial begin
        rst   = 1'b1;
        m_rst = 1'b1;
        model_reset();
        idle();
        rd(0, 5); rd(1, 5);
        #2;
        check_all("reset");
        chk("reset.rdata_const", 64'(bus.rdata_o), 64'(0));
        @(negedge clk);
        rst = 1'b0; m_rst = 1'b0;
        #1;

        // WB write with same-cycle bypass, then read from the array
        idle();
        bus.wb_we_i = 1; bus.wb_waddr_i = 3; bus.wb_wdata_i = 32'h1234;
        rd(0, 3);
        #1;
        chk("wb_bypass", 64'(bus.rdata_o[31:0]), 64'h1234);
        check_all("wb_bypass");
        tick();
        idle(); rd(0, 3);
        #1;
        chk("regs_x3", 64'(bus.rdata_o[31:0]), 64'h1234);
        check_all("regs_x3");
        idle();
        bus.wb_we_i = 1; bus.wb_waddr_i = 0; bus.wb_wdata_i = 32'hFFFF;
        rd(1, 0);
        #1;
        check_all("wr_x0");
        tick();
        idle(); rd(0, 0); rd(1, 0);
        #1;
        chk("x0_zero", 64'(bus.rdata_o), 64'(0));
        check_all("x0_zero");

        // EX has priority over MEM; EX load forces a stall
        idle();
        bus.ex_we_i = 1; bus.ex_waddr_i = 7; bus.ex_alu_i = 32'hA;
        bus.mem_we_i = 1; bus.mem_waddr_i = 7; bus.mem_wdata_i = 32'hB;
        rd(0, 7);
        #1;
        chk("ex_over_mem", 64'(bus.rdata_o[31:0]), 64'hA);
        check_all("ex_over_mem");
        bus.ex_ld_i = 1;
        #1;
        chk("ex_ld.stall", 64'(bus.stallreq_o), 64'(1));
        chk("ex_ld.data",  64'(bus.rdata_o[31:0]), 64'(0));
        idle();
        #1;

        // pending load to x9
        bus.ld_issue_i = 1; bus.ld_issue_addr_i = 9;
        #1;
        tick();
        for (int c = 0; c < 3; c++) begin
            idle(); rd(0, 9);
            #1;
            chk("pend_x9.stall", 64'(bus.stallreq_o), 64'(1));
            check_all("pend_x9");
            tick();
        end
        idle();
        #1;
        chk("pend_x9.cnt3", 64'(bus.stall_cnt_o), 64'(3));
        bus.wb_we_i = 1; bus.wb_ld_i = 1; bus.wb_waddr_i = 9; bus.wb_wdata_i = 32'h55;
        rd(0, 9);
        #1;
        chk("ld_ret.data",  64'(bus.rdata_o[31:0]), 64'h55);
        chk("ld_ret.stall", 64'(bus.stallreq_o), 64'(0));
        tick();
        idle();
        #1;
        chk("ld_ret.pend9", 64'(bus.pending_o[9]), 64'(0));

        // set beats clear on the same register
        bus.ld_issue_i = 1; bus.ld_issue_addr_i = 4;
        bus.wb_we_i = 1; bus.wb_ld_i = 1; bus.wb_waddr_i = 4; bus.wb_wdata_i = 32'h77;
        #1;
        tick();
        idle();
        #1;
        chk("set_wins.pend4", 64'(bus.pending_o[4]), 64'(1));
        check_all("set_wins");

        // randomized traffic on a narrow address range to force collisions
        for (int n = 0; n < 250; n++) begin
            idle();
            bus.wb_we_i         = ($urandom_range(0, 1) == 1);
            bus.wb_ld_i         = ($urandom_range(0, 1) == 1);
            bus.wb_waddr_i      = AW'($urandom_range(0, 7));
            bus.wb_wdata_i      = $urandom;
            bus.mem_we_i        = ($urandom_range(0, 2) == 0);
            bus.mem_ld_i        = ($urandom_range(0, 3) == 0);
            bus.mem_waddr_i     = AW'($urandom_range(0, 7));
            bus.mem_wdata_i     = $urandom;
            bus.ex_we_i         = ($urandom_range(0, 2) == 0);
            bus.ex_ld_i         = ($urandom_range(0, 3) == 0);
            bus.ex_waddr_i      = AW'($urandom_range(0, 7));
            bus.ex_alu_i        = $urandom;
            bus.ld_issue_i      = ($urandom_range(0, 4) == 0);
            bus.ld_issue_addr_i = AW'($urandom_range(0, 7));
            bus.re_i            = NRD'($urandom_range(0, 3));
            for (int k = 0; k < NRD; k++) bus.raddr_i[k*AW +: AW] = AW'($urandom_range(0, 7));
            #1;
            check_all("rand");
            tick();
        end

        // asynchronous reset between edges clears state at once
        idle();
        #2;
        rst = 1'b1; m_rst = 1'b1;
        model_reset();
        #1;
        chk("arst1.cnt",  64'(bus.stall_cnt_o), 64'(0));
        chk("arst1.pend", 64'(bus.pending_o), 64'(0));
        @(negedge clk);
        rst = 1'b0; m_rst = 1'b0;
        #1;

        // saturation of the stall counter
        bus.ld_issue_i = 1; bus.ld_issue_addr_i = 12;
        #1;
        tick();
        idle(); rd(1, 12);
        for (int c = 0; c < (1 << CNTW) + 5; c++) begin
            #1;
            if (c == 0 || c == 16) check_all("sat");
            tick();
        end
        #1;
        chk("sat.cnt15", 64'(bus.stall_cnt_o), 64'(15));
        check_all("sat_end");

        // reset mid-stall
        #1;
        rst = 1'b1; m_rst = 1'b1;
        model_reset();
        #1;
        chk("arst2.cnt",   64'(bus.stall_cnt_o), 64'(0));
        chk("arst2.pend",  64'(bus.pending_o), 64'(0));
        chk("arst2.stall", 64'(bus.stallreq_o), 64'(0));
        chk("arst2.rdata", 64'(bus.rdata_o), 64'(0));
        @(negedge clk);
        rst = 1'b0; m_rst = 1'b0;
        idle(); rd(0, 3);
        #1;
        check_all("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
